seq_subtractor_64bit: RTL and testbench

Digit-serial 64-bit subtractor computing D = A − B − bin over WIDTH/DIGIT clock cycles with a start/done handshake. It is the inverse-direction companion to the team's 64-bit ripple-carry adder. It is built from one combinational DIGIT-wide ripple-borrow stage reused every cycle, trading latency for area. It sits in the datapath as the multi-cycle SUB unit, next to the adder.

---
 rtl/sub_defs.sv | 17 +
 rtl/sub_stage_digit.sv | 34 +++
 rtl/seq_subtractor_64bit.sv | 161 ++++++++++++++++
 tb/tb_seq_subtractor_64bit.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/sub_defs.sv
// ---------------------------------------------------------------------------
// sub_defs
//   Shared definitions for the digit-serial subtractor: default operand and
//   digit widths and the controller state encoding.
// ---------------------------------------------------------------------------
package sub_defs;

    localparam int unsigned WIDTH_DEF = 64;
    localparam int unsigned DIGIT_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : sub_defs

// File: rtl/sub_stage_digit.sv
// ---------------------------------------------------------------------------
// sub_stage_digit
//   Combinational DIGIT-wide ripple-borrow subtractor: d = a - b - bin.
//   Built from full-subtractor cells chained through the borrow.
//
//   Ports:
//     a    [DIGIT-1:0]  minuend digit
//     b    [DIGIT-1:0]  subtrahend digit
//     bin               borrow-in
//     d    [DIGIT-1:0]  difference digit
//     bout              borrow-out of the most significant cell
// ---------------------------------------------------------------------------
module sub_stage_digit #(
    parameter int unsigned DIGIT = 8
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             bin,
    output logic [DIGIT-1:0] d,
    output logic             bout
);

    logic [DIGIT:0] brw;

    assign brw[0] = bin;

    for (genvar i = 0; i < DIGIT; i++) begin : g_cell
        assign d[i]     = a[i] ^ b[i] ^ brw[i];
        assign brw[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & brw[i]);
    end

    assign bout = brw[DIGIT];

endmodule : sub_stage_digit

// File: rtl/seq_subtractor_64bit.sv
// ---------------------------------------------------------------------------
// seq_subtractor_64bit
//   Digit-serial subtractor computing D = A - B - bin over WIDTH/DIGIT cycles
//   using one reused DIGIT-wide ripple-borrow stage. The inter-digit borrow is
//   registered, so the critical path is a single DIGIT-bit ripple.
//
//   Ports:
//     clk    rising-edge clock
//     rst    synchronous, active-high reset
//     start  request, accepted when idle (or on the done cycle)
//     A, B   operands, captured on an accepted start
//     bin    borrow-in, captured on an accepted start
//     busy   high while digits are being processed
//     done   one-cycle pulse, results valid
//     D      registered difference
//     bout   final borrow (unsigned A < B + bin)
//     ovf    signed overflow
// ---------------------------------------------------------------------------
module seq_subtractor_64bit
    import sub_defs::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned DIGIT = DIGIT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             bout,
    output logic             ovf
);

    localparam int unsigned N     = WIDTH / DIGIT;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [WIDTH-1:0]   d_sh_q, d_sh_d;
    logic               brw_q, brw_d;
    logic               a_sgn_q, a_sgn_d;
    logic               b_sgn_q, b_sgn_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               bout_q, bout_d;
    logic               ovf_q, ovf_d;

    logic [DIGIT-1:0]       stage_d;
    logic                   stage_bout;
    logic [WIDTH+DIGIT-1:0] d_cat;
    logic [WIDTH-1:0]       d_shift;
    logic                   accept;

    sub_stage_digit #(
        .DIGIT (DIGIT)
    ) u_stage (
        .a    (a_sh_q[DIGIT-1:0]),
        .b    (b_sh_q[DIGIT-1:0]),
        .bin  (brw_q),
        .d    (stage_d),
        .bout (stage_bout)
    );

    // New digit enters at the top; after N shifts digit 0 sits at the bottom.
    assign d_cat   = {stage_d, d_sh_q};
    assign d_shift = d_cat[WIDTH+DIGIT-1:DIGIT];

    // The done cycle also accepts start, giving back-to-back operations
    // every N+1 cycles when start is held high.
    assign accept = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        d_sh_d  = d_sh_q;
        brw_d   = brw_q;
        a_sgn_d = a_sgn_q;
        b_sgn_d = b_sgn_q;
        res_d   = res_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_IDLE;
            end
            ST_RUN: begin
                a_sh_d = a_sh_q >> DIGIT;
                b_sh_d = b_sh_q >> DIGIT;
                d_sh_d = d_shift;
                brw_d  = stage_bout;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(N - 1)) begin
                    res_d   = d_shift;
                    bout_d  = stage_bout;
                    ovf_d   = (a_sgn_q != b_sgn_q) && (stage_d[DIGIT-1] != a_sgn_q);
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (accept) begin
            a_sh_d  = A;
            b_sh_d  = B;
            brw_d   = bin;
            a_sgn_d = A[WIDTH-1];
            b_sgn_d = B[WIDTH-1];
            cnt_d   = '0;
            state_d = ST_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            d_sh_q  <= '0;
            brw_q   <= 1'b0;
            a_sgn_q <= 1'b0;
            b_sgn_q <= 1'b0;
            res_q   <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            d_sh_q  <= d_sh_d;
            brw_q   <= brw_d;
            a_sgn_q <= a_sgn_d;
            b_sgn_q <= b_sgn_d;
            res_q   <= res_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
    assign D    = res_q;
    assign bout = bout_q;
    assign ovf  = ovf_q;

endmodule : seq_subtractor_64bit

// File: tb/tb_seq_subtractor_64bit.sv
// ---------------------------------------------------------------------------
// tb_seq_subtractor_64bit
//   Directed-vector bench for seq_subtractor_64bit with hand-computed results.
// ---------------------------------------------------------------------------
module tb_seq_subtractor_64bit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [63:0] A;
    logic [63:0] B;
    logic        bin;
    logic        busy;
    logic        done;
    logic [63:0] D;
    logic        bout;
    logic        ovf;

    int n_checks;
    int n_fail;
    logic [63:0] prev_d;

    seq_subtractor_64bit #(
        .WIDTH (64),
        .DIGIT (8)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .D     (D),
        .bout  (bout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    // One operation: start for a single cycle, scramble operands afterwards,
    // optionally poke a stray start mid-run, then check latency and results.
    task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                          input logic bi, input logic [63:0] exp_d,
                          input logic exp_b, input logic exp_o, input logic poke);
        int lat;
        int busy_n;
        int extra;
        lat    = 0;
        busy_n = 0;
        extra  = 0;
        @(negedge clk);
        A = a; B = b; bin = bi; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; A = ~a; B = ~b; bin = ~bi;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (poke && k == 3) begin
                start = 1'b1; A = 64'd34; B = 64'd57; bin = 1'b0;
            end
            if (poke && k == 4) start = 1'b0;
            if (k == 4) check({tag, "_hold"}, D, prev_d);
            if (done) begin
                lat = k - 1;
                break;
            end
            if (busy) busy_n++;
        end
        check({tag, "_lat"}, 64'(lat), 64'd8);
        check({tag, "_busy"}, 64'(busy_n), 64'd8);
        check({tag, "_D"}, D, exp_d);
        check({tag, "_bout"}, 64'(bout), 64'(exp_b));
        check({tag, "_ovf"}, 64'(ovf), 64'(exp_o));
        prev_d = exp_d;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done) extra++;
        end
        check({tag, "_1pulse"}, 64'(extra), 64'd0);
        check({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int extra;
        int idx;
        int ndone;
        int t_done[3];

        n_checks = 0;
        n_fail   = 0;
        prev_d   = '0;
        rst   = 1'b1;
        start = 1'b0;
        A     = '0;
        B     = '0;
        bin   = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_D", D, 64'd0);
        check("rst_bout", 64'(bout), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        rst = 1'b0;

        run_op("basic", 64'd100, 64'd24, 1'b0, 64'd76, 1'b0, 1'b0, 1'b0);
        run_op("neg", 64'd24, 64'd100, 1'b0, 64'hFFFF_FFFF_FFFF_FFB4, 1'b1, 1'b0, 1'b0);
        run_op("ovf_lo", 64'h8000_0000_0000_0000, 64'd1, 1'b0,
               64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0);
        run_op("ovf_hi", 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
               64'h8000_0000_0000_0000, 1'b1, 1'b1, 1'b0);
        run_op("bin", 64'd0, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0);
        run_op("equal", 64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567, 1'b0,
               64'd0, 1'b0, 1'b0, 1'b0);
        run_op("ignore", 64'd98, 64'd40, 1'b0, 64'd58, 1'b0, 1'b0, 1'b1);

        // Continuous start: done pulses must be 9 cycles apart.
        @(negedge clk);
        A = 64'd100; B = 64'd24; bin = 1'b0; start = 1'b1;
        ndone = 0;
        for (int k = 0; k < 40 && ndone < 3; k++) begin
            @(negedge clk);
            if (done) begin
                t_done[ndone] = k;
                ndone++;
            end
        end
        check("cont_count", 64'(ndone), 64'd3);
        if (ndone == 3) begin
            check("cont_gap1", 64'(t_done[1] - t_done[0]), 64'd9);
            check("cont_gap2", 64'(t_done[2] - t_done[1]), 64'd9);
        end
        check("cont_D", D, 64'd76);
        start = 1'b0;
        repeat (12) @(negedge clk);

        // Reset in the 4th RUN cycle discards the operation.
        @(negedge clk);
        A = 64'd100; B = 64'd24; bin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_D", D, 64'd0);
        check("mid_rst_bout", 64'(bout), 64'd0);
        check("mid_rst_ovf", 64'(ovf), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        extra = 0;
        for (idx = 0; idx < 15; idx++) begin
            @(negedge clk);
            if (done) extra++;
        end
        check("mid_rst_nodone", 64'(extra), 64'd0);
        prev_d = '0;
        run_op("after_rst", 64'd98, 64'd40, 1'b0, 64'd58, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_seq_subtractor_64bit
